// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Reassembles frames into parallel words and presents them under a Valid/Ack handshake.
module serial_frame_receiver #(
    parameter int unsigned WIDTH  = 4,
    parameter bit          PARITY = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             SerialIn,
    input  logic             Dir,
    input  logic             Ack,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             ParityError,
    output logic             FramingError,
    output logic             Overrun,
    output logic             Busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] q_q;
    logic             perr_pend_q;
    logic             perr_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;
    logic             last_data;

    // Direction is the one latched at the start bit, not the live Dir input.
    always_comb begin
        sr_d = sr_q;
        if (dir_q) begin
            sr_d = {sr_q[WIDTH-2:0], SerialIn};
        end else begin
            sr_d = {SerialIn, sr_q[WIDTH-1:1]};
        end
    end

    assign last_data = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            sr_q        <= '0;
            q_q         <= '0;
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (valid_q && Ack) begin
                valid_q <= 1'b0;
            end
            if (Enable) begin
                case (state_q)
                    S_IDLE: begin
                        if (!SerialIn) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            dir_q   <= Dir;
                        end
                    end
                    S_DATA: begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_data) begin
                            state_q <= PARITY ? S_PAR : S_STOP;
                        end
                    end
                    S_PAR: begin
                        perr_pend_q <= PARITY & (SerialIn ^ (^sr_q));
                        state_q     <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        // A good frame overrides a same-edge Ack clear; only an unacked word overruns.
                        if (SerialIn) begin
                            q_q     <= sr_q;
                            perr_q  <= perr_pend_q;
                            valid_q <= 1'b1;
                            if (valid_q && !Ack) begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign Q            = q_q;
    assign Valid        = valid_q;
    assign ParityError  = perr_q;
    assign FramingError = ferr_q;
    assign Overrun      = ovr_q;
    assign Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=4, PARITY=1) with hand-computed expectations.
module tb_serial_frame_receiver;

    logic       Clock;
    logic       Reset;
    logic       Enable;
    logic       SerialIn;
    logic       Dir;
    logic       Ack;
    logic [3:0] Q;
    logic       Valid;
    logic       ParityError;
    logic       FramingError;
    logic       Overrun;
    logic       Busy;

    int n_cmp;
    int n_err;

    serial_frame_receiver #(.WIDTH(4), .PARITY(1'b1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .SerialIn    (SerialIn),
        .Dir         (Dir),
        .Ack         (Ack),
        .Q           (Q),
        .Valid       (Valid),
        .ParityError (ParityError),
        .FramingError(FramingError),
        .Overrun     (Overrun),
        .Busy        (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one strobed bit; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        SerialIn = b;
        Enable   = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    // Send the n leading bits of seq, seq[6] first.
    task automatic send_seq(input logic [6:0] seq, input int n);
        for (int i = 6; i > 6 - n; i--) begin
            send_bit(seq[i]);
        end
    endtask

    task automatic idle_cycle();
        SerialIn = 1'b1;
        Enable   = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_ack();
        Ack      = 1'b1;
        SerialIn = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        Reset    = 1'b1;
        Enable   = 1'b0;
        SerialIn = 1'b1;
        Dir      = 1'b0;
        Ack      = 1'b0;
        #3;
        check("rst_q", 32'(Q), 0);
        check("rst_valid", 32'(Valid), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_ovr", 32'(Overrun), 0);
        check("rst_ferr", 32'(FramingError), 0);
        check("rst_perr", 32'(ParityError), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        idle_cycle();
        check("idle_busy", 32'(Busy), 0);

        // MSB first: word 0110, parity 0
        Dir = 1'b1;
        send_bit(1'b0);
        check("msb_busy_start", 32'(Busy), 1);
        send_seq(7'b0110_0_1_0, 6);
        check("msb_q", 32'(Q), 32'h6);
        check("msb_valid", 32'(Valid), 1);
        check("msb_perr", 32'(ParityError), 0);
        check("msb_busy_end", 32'(Busy), 0);
        pulse_ack();
        check("msb_ack_valid", 32'(Valid), 0);

        // LSB first: line bits 1,1,0,1 form word 1011, parity 1
        Dir = 1'b0;
        send_seq(7'b0110111, 6);
        check("lsb_not_yet_valid", 32'(Valid), 0);
        send_bit(1'b1);
        check("lsb_q", 32'(Q), 32'hB);
        check("lsb_perr", 32'(ParityError), 0);
        check("lsb_valid", 32'(Valid), 1);
        pulse_ack();
        check("lsb_ack_valid", 32'(Valid), 0);
        check("lsb_ovr", 32'(Overrun), 0);

        // Parity error with a 3-cycle Enable gap mid-data
        Dir = 1'b1;
        send_seq(7'b0010000, 3);
        Enable   = 1'b0;
        SerialIn = 1'b0;
        Dir      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
        end
        check("gap_busy", 32'(Busy), 1);
        check("gap_valid", 32'(Valid), 0);
        Dir = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("perr_busy_before_stop", 32'(Busy), 1);
        send_bit(1'b1);
        check("perr_q", 32'(Q), 32'h6);
        check("perr_valid", 32'(Valid), 1);
        check("perr_flag", 32'(ParityError), 1);
        pulse_ack();
        check("perr_ack_valid", 32'(Valid), 0);
        pulse_ack();
        check("ack_idle_ignored", 32'(Valid), 0);

        // Framing error: 1111, parity 0, stop 0
        send_seq(7'b0111100, 7);
        check("fe_pulse", 32'(FramingError), 1);
        check("fe_q", 32'(Q), 32'h6);
        check("fe_valid", 32'(Valid), 0);
        check("fe_busy", 32'(Busy), 0);
        check("fe_perr_kept", 32'(ParityError), 1);
        idle_cycle();
        check("fe_one_cycle", 32'(FramingError), 0);
        check("fe_no_restart", 32'(Busy), 0);
        send_seq(7'b0001101, 7);
        check("after_fe_q", 32'(Q), 32'h3);
        check("after_fe_valid", 32'(Valid), 1);
        check("after_fe_perr", 32'(ParityError), 0);

        // Overrun: second frame 1100 with no Ack
        send_seq(7'b0110001, 7);
        check("ovr_flag", 32'(Overrun), 1);
        check("ovr_q", 32'(Q), 32'hC);
        check("ovr_valid", 32'(Valid), 1);
        idle_cycle();
        check("ovr_sticky", 32'(Overrun), 1);

        Reset = 1'b1;
        #2;
        check("rst2_ovr", 32'(Overrun), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Same-edge Ack with a good stop strobe
        send_seq(7'b0010101, 7);
        check("se_first_q", 32'(Q), 32'h5);
        check("se_first_valid", 32'(Valid), 1);
        send_seq(7'b0101001, 6);
        Ack = 1'b1;
        send_bit(1'b1);
        Ack = 1'b0;
        check("se_valid", 32'(Valid), 1);
        check("se_ovr", 32'(Overrun), 0);
        check("se_q", 32'(Q), 32'hA);

        // Reset mid-frame after 2 data bits
        send_seq(7'b0100000, 3);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_q", 32'(Q), 0);
        check("mid_rst_valid", 32'(Valid), 0);
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_ovr", 32'(Overrun), 0);
        #1;
        Reset = 1'b0;
        send_seq(7'b0100101, 7);
        check("post_rst_q", 32'(Q), 32'h9);
        check("post_rst_valid", 32'(Valid), 1);
        check("post_rst_perr", 32'(ParityError), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receives serial frames produced by the team's shift-register transmitter and reassembles them into parallel words. Each frame is a start bit (0), WIDTH data bits, an optional even-parity bit, and a stop bit (1). `Enable` acts as the bit strobe. The received word is presented on `Q` under a Valid/Ack handshake, with parity, framing and overrun status. It is the receiving end of the serial link between shift-register stages and downstream parallel logic.

## Interface
- `WIDTH`, default 4: data bits per frame; must be ≥ 2.
- `PARITY`, default 1: 1 means a parity bit follows the data (even parity over the data bits); 0 means no parity bit.
- `Clock` input, 1 bit: rising-edge clock.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `Enable` input, 1 bit: bit strobe. The block samples `SerialIn` and advances only on edges where `Enable`=1.
- `SerialIn` input, 1 bit: serial line; idles high.
- `Dir` input, 1 bit: bit order. 1 means MSB first (shift left; the new bit enters bit 0). 0 means LSB first (shift right; the new bit enters bit WIDTH-1).
- `Ack` input, 1 bit: the consumer accepts `Q` while `Valid`=1.
- `Q` output, WIDTH bits: last good word.
- `Valid` output, 1 bit: `Q` holds an unacknowledged word.
- `ParityError` output, 1 bit: parity status of the word in `Q`. Always 0 when `PARITY`=0.
- `FramingError` output, 1 bit: one-cycle pulse when a bad stop bit is sampled.
- `Overrun` output, 1 bit: sticky flag; an unacknowledged word was overwritten.
- `Busy` output, 1 bit: a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, DATA, PAR, STOP. Edges with `Enable`=0 freeze the state, bit counter and shift register. The Ack handling below still applies on those edges.
- **IDLE.** On a strobe with `SerialIn`=0, go to DATA, clear the counter and latch `Dir` into the frame direction. A strobe with `SerialIn`=1 stays in IDLE.
- **DATA.** Each strobe shifts `SerialIn` into the shift register in the latched direction and increments the counter. After the WIDTH-th data strobe, go to PAR if `PARITY`=1, otherwise go to STOP.
- **PAR.** One strobe. Store `SerialIn` XOR (XOR of the data bits) as the pending parity error, then go to STOP.
- **STOP.** One strobe, then return to IDLE in all cases.
  - `SerialIn`=1 (good frame): `Q` ← shift register, `ParityError` ← pending error, `Valid` ← 1.
  - `SerialIn`=0 (bad stop bit): `FramingError`=1 for exactly one cycle. `Q`, `Valid` and `ParityError` are unchanged, and the frame is discarded.
- **Handshake.** `Valid`=1 and `Ack`=1 at an edge clears `Valid` at that edge, unless a good frame completes at the same edge; in that case `Valid` stays 1 with the new word and `Overrun` is not set. `Ack` while `Valid`=0 is ignored.
- **Overrun.** A good frame completing while `Valid`=1 and `Ack`=0 overwrites `Q` and sets `Overrun`=1. `Overrun` clears only on `Reset`.
- A low `SerialIn` on the stop strobe never starts a new frame; start detection happens only in IDLE.

## Timing
- **Reset** (asynchronous, effective immediately, including mid-frame): state IDLE, counter 0, shift register 0, `Q`=0, `Valid`=0, `ParityError`=0, `FramingError`=0, `Overrun`=0, `Busy`=0.
- **Frame length:** 2 + WIDTH + PARITY strobes, which is 7 for the defaults.
- `Busy` rises at the edge that samples the start bit and falls at the edge that samples the stop bit.
- `Valid`, `Q` and `ParityError` update at the stop-strobe edge and are visible in the following cycle. With a continuous `Enable`, `Valid` therefore follows the start-bit edge by 6 cycles for the defaults.
- `FramingError` is high for the single cycle after the bad stop-bit edge.
- Back-to-back frames are supported: a start bit may be sampled on the strobe immediately after the stop strobe.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use the defaults (WIDTH=4, PARITY=1) with `Enable`=1 unless stated.
- **MSB first.** `Dir`=1; send 0,0,1,1,0,0,1 (start, data 0110, parity 0, stop) → after the stop edge: `Q`=0110, `Valid`=1, `ParityError`=0, `Busy`=0.
- **LSB first.** `Dir`=0; send 0,1,1,0,1,1,1 (word 1011, parity 1) → `Q`=1011, `ParityError`=0. Then pulse `Ack` → `Valid`=0 on the next edge.
- **Parity error and strobe gating.** `Dir`=1; send 0110 with parity bit 1, holding `Enable`=0 for 3 cycles mid-data → state is frozen during the gap; `Q`=0110, `Valid`=1, `ParityError`=1.
- **Framing error.** Start from `Q`=0110, `Valid`=0. Send a frame for 1111 with stop bit 0 → `FramingError` high for exactly 1 cycle; `Q`=0110 and `Valid`=0 unchanged; `Busy`=0; the next frame is received normally.
- **Overrun and same-edge Ack.**
  - Two frames with no `Ack` → `Overrun`=1 and `Q`=the second word.
  - After `Reset`: `Ack`=1 on the same edge as a stop strobe while `Valid`=1 → `Valid` stays 1, `Overrun`=0.
- **Reset mid-frame.** Assert `Reset` after 2 data bits, between clock edges → all outputs 0 immediately. After release, a full frame for 1001 yields `Q`=1001, `Valid`=1.
